text_buffer_arbiter: RTL and testbench
======================================

# text_buffer_arbiter

Owns the single-port character-cell buffer behind the VGA text renderer and shares it between two requesters. The pixel scan side issues cell reads during active video. A user or keyboard writer pushes characters through a valid/ready handshake. A clear engine sweeps the whole buffer to zero on command. The block sits between the VGA timing/bitmap stage, which consumes `rd_data` to index glyph bitmaps, and the input front end, which produces `wr_*` transactions.

## Interface
- `COLS`, 32, cells per row; must be a power of two.
- `ROWS`, 16, rows of cells; must be a power of two.
- `CHAR_W`, 7, bits per stored character code.
- Derived: `CW = log2(COLS)`, `RW = log2(ROWS)`, `AW = CW + RW`.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `rd_req`  in  1  display read request for this cycle.
- `rd_col`  in  CW  display cell column.
- `rd_row`  in  RW  display cell row.
- `rd_valid`  out  1  `rd_data` valid; asserted one cycle after `rd_req`.
- `rd_data`  out  CHAR_W  character code read from the buffer.
- `wr_valid`  in  1  writer has a character to store.
- `wr_ready`  out  1  writer transfer accepted this cycle.
- `wr_col`  in  CW  writer cell column.
- `wr_row`  in  RW  writer cell row.
- `wr_char`  in  CHAR_W  writer character code.
- `clr_start`  in  1  single-cycle pulse that starts a full-buffer clear.
- `busy`  out  1  clear in progress.

## Operation
- Cell address is `{row, col}`, AW bits wide. No out-of-range cells exist.
- State machine:
  - IDLE → CLEAR when `clr_start` is seen in IDLE.
  - CLEAR → IDLE after cell `COLS*ROWS-1` has been written.
  - `clr_start` is ignored while in CLEAR.
- Priority per cycle, fixed: display read > clear write > writer write. At most one RAM access per cycle.
- Display read:
  - `rd_req` high → RAM read at `{rd_row, rd_col}`.
  - `rd_valid` = registered `rd_req`.
  - `rd_data` holds its last value when `rd_valid` is low.
- Writer:
  - `wr_ready` = (state == IDLE) && !`rd_req` && !`clr_start`. It is combinational.
  - A transfer occurs when `wr_valid && wr_ready`. `wr_char` is written at `{wr_row, wr_col}` on that edge.
  - `wr_valid` may wait indefinitely; the writer holds its fields stable until a transfer occurs.
- Clear:
  - An AW-bit sweep counter starts at 0.
  - Each cycle in CLEAR with `rd_req` low: write 0 to the counter's address and increment.
  - A cycle with `rd_req` high stalls the sweep and does not advance the counter.
  - A read during CLEAR returns the current stored value, so a partially cleared frame is legal.
- RAM contents are zero at configuration and are not affected by `rst`.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `busy`=0, state IDLE, sweep counter 0. `wr_ready` is 0 during reset.
- Read latency: exactly 1 cycle, every request, with no stalls.
- Write: takes effect at the accepting edge. A read of the same cell on the next cycle returns the new value.
- `busy` rises the cycle after `clr_start`. It falls the cycle after the final clear write.
- Clear duration: `COLS*ROWS` cycles plus the number of `rd_req` cycles overlapping the clear.
- Simultaneous events:
  - `rd_req` and `clr_start` together: the read is served and CLEAR is entered next cycle.
  - `wr_valid` and `clr_start` together: no transfer; the writer is refused until the clear ends.
- `rst` asserted mid-clear: the clear aborts, the state returns to IDLE, and already-cleared cells stay cleared.

## Configuration
- `TEXT_BUFFER_CURSOR_EN` defined: the block adds the following.
  - Input `wr_auto` (1 bit).
  - Outputs `cur_col` (CW bits) and `cur_row` (RW bits).
  - A transfer with `wr_auto`=1 ignores `wr_col`/`wr_row`, writes at the cursor, and then advances the cursor.
  - Cursor advance: column+1. Wrap from col `COLS-1` to col 0 of row+1. Wrap from the last cell to (0,0).
  - The cursor resets to (0,0) on `rst` and on clear completion.
- Not defined: no cursor ports or registers. Every write uses `wr_col`/`wr_row`.

## Structure
- Shared package `text_pkg`:
  - State enum (IDLE, CLEAR).
  - Default `COLS`/`ROWS`/`CHAR_W` constants.
  - Address-width helper function.
- One sub-module, `text_ram`:
  - Single-port, synchronous read (1-cycle latency), write-first.
  - Depth `COLS*ROWS`, width `CHAR_W`.
- The arbiter selects that sub-module's address, write-enable and data inputs.

## Test plan
- Write then read:
  - Stimulus: write 0x41 at (3,5) with `rd_req` low, then `rd_req` at (3,5).
  - Required: `wr_ready`=1 on the write cycle; next cycle `rd_valid`=1 and `rd_data`=0x41.
- Read priority:
  - Stimulus: hold `wr_valid` and `rd_req` high for 10 cycles.
  - Required: `wr_ready`=0 for all 10 cycles; the write completes on the first cycle with `rd_req` low.
- Full clear:
  - Stimulus: fill all cells with 0x7F, pulse `clr_start`.
  - Required: `busy` is high for 512 cycles (defaults); every cell then reads 0.
- Clear with read stalls:
  - Stimulus: `rd_req` high on 20 cycles during a clear.
  - Required: `busy` lasts 532 cycles; each read returns within 1 cycle.
- Reset mid-clear:
  - Stimulus: assert `rst` at sweep count 100.
  - Required: `busy`=0 the next cycle; cells 0–99 read 0 and cell 100 holds 0x7F.
- Cursor wrap (with `TEXT_BUFFER_CURSOR_EN`):
  - Stimulus: 512 `wr_auto` writes.
  - Required: the cursor returns to (0,0); writes 31→32 move it from (row 0, col 31) to (row 1, col 0).

Source files
------------

// File: rtl/text_buffer_arbiter_pkg.sv
// text_pkg: shared definitions for the VGA text-buffer arbiter slice.
//   - default geometry (DEF_COLS x DEF_ROWS cells, DEF_CHAR_W-bit codes)
//   - arbiter state encoding
//   - addr_width(): cell-address width for a given geometry
// Optional feature macro used by this slice: TEXT_BUFFER_CURSOR_EN.
package text_pkg;

    localparam int unsigned DEF_COLS   = 32;
    localparam int unsigned DEF_ROWS   = 16;
    localparam int unsigned DEF_CHAR_W = 7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Address is {row, col}; both dimensions are powers of two.
    function automatic int unsigned addr_width(input int unsigned cols, input int unsigned rows);
        return $clog2(cols) + $clog2(rows);
    endfunction

endpackage

// File: rtl/text_buffer_arbiter_if.sv
// text_buffer_arbiter_if: display-read, writer and clear-control signals
// between the VGA front end (master) and the text-buffer arbiter (slave).
//   rd_req/rd_col/rd_row -> rd_valid/rd_data   display cell read
//   wr_valid/wr_col/wr_row/wr_char <-> wr_ready writer handshake
//   clr_start -> busy                          full-buffer clear
//   TEXT_BUFFER_CURSOR_EN adds wr_auto, cur_col, cur_row.
interface text_buffer_arbiter_if
    import text_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned CHAR_W = DEF_CHAR_W
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    logic              rd_req;
    logic [CW-1:0]     rd_col;
    logic [RW-1:0]     rd_row;
    logic              rd_valid;
    logic [CHAR_W-1:0] rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [CW-1:0]     wr_col;
    logic [RW-1:0]     wr_row;
    logic [CHAR_W-1:0] wr_char;
    logic              clr_start;
    logic              busy;
`ifdef TEXT_BUFFER_CURSOR_EN
    logic              wr_auto;
    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;

    modport master (
        output rd_req, rd_col, rd_row, wr_valid, wr_col, wr_row, wr_char, clr_start, wr_auto,
        input  rd_valid, rd_data, wr_ready, busy, cur_col, cur_row
    );
    modport slave (
        input  rd_req, rd_col, rd_row, wr_valid, wr_col, wr_row, wr_char, clr_start, wr_auto,
        output rd_valid, rd_data, wr_ready, busy, cur_col, cur_row
    );
`else
    modport master (
        output rd_req, rd_col, rd_row, wr_valid, wr_col, wr_row, wr_char, clr_start,
        input  rd_valid, rd_data, wr_ready, busy
    );
    modport slave (
        input  rd_req, rd_col, rd_row, wr_valid, wr_col, wr_row, wr_char, clr_start,
        output rd_valid, rd_data, wr_ready, busy
    );
`endif

endinterface

// File: rtl/text_buffer_arbiter_ram.sv
// text_ram: single-port character-cell RAM, synchronous read with 1-cycle
// latency, write-first when read and write coincide.
//   clk, rst   clock; rst clears only the output register, never the array
//   re         read enable; rdata updates only on re, otherwise holds
//   we         write enable
//   addr       cell address
//   wdata      data to store
//   rdata      registered read data
module text_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage array: contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/text_buffer_arbiter.sv
// text_buffer_arbiter: shares the single-port text buffer between the
// display scan (reads), a clear engine and a character writer.
// Fixed priority per cycle: display read > clear write > writer write.
//   clk   pixel clock
//   rst   synchronous active-high reset (RAM contents are kept)
//   bus   text_buffer_arbiter_if.slave: rd_*, wr_*, clr_start, busy
// Optional: TEXT_BUFFER_CURSOR_EN adds an auto-advancing write cursor
// (bus.wr_auto input, bus.cur_col/bus.cur_row outputs).
module text_buffer_arbiter
    import text_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned CHAR_W = DEF_CHAR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    text_buffer_arbiter_if.slave bus
);

    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned AW    = addr_width(COLS, ROWS);
    localparam int unsigned DEPTH = COLS * ROWS;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [0:0] IDLE  = 1'(ST_IDLE);
    localparam logic [0:0] CLEAR = 1'(ST_CLEAR);

    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     sweep_q, sweep_d;
    logic              busy_q;
    logic              rd_valid_q;

    logic              wr_ready_c;
    logic              wr_fire_c;
    logic              clr_wr_c;
    logic              clr_done_c;
    logic [AW-1:0]     rd_addr_c;
    logic [AW-1:0]     wr_addr_c;

    logic              ram_re;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [CHAR_W-1:0] ram_wdata;
    logic [CHAR_W-1:0] ram_rdata;

    // Writer is only served on otherwise idle cycles; a clr_start cycle
    // refuses it so the clear sees a consistent buffer.
    assign wr_ready_c = !rst && (state_q == IDLE) && !bus.rd_req && !bus.clr_start;
    assign wr_fire_c  = bus.wr_valid && wr_ready_c;

    // Clear writes only on cycles the display leaves free.
    assign clr_wr_c   = !rst && (state_q == CLEAR) && !bus.rd_req;
    assign clr_done_c = clr_wr_c && (sweep_q == LAST_ADDR);

    assign rd_addr_c  = {bus.rd_row, bus.rd_col};

`ifdef TEXT_BUFFER_CURSOR_EN
    logic [AW-1:0] cur_q;

    assign wr_addr_c = bus.wr_auto ? cur_q : {bus.wr_row, bus.wr_col};

    // Cursor walks row-major and wraps from the last cell to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= '0;
        end else if (clr_done_c) begin
            cur_q <= '0;
        end else if (wr_fire_c && bus.wr_auto) begin
            cur_q <= cur_q + AW'(1);
        end
    end

    assign bus.cur_col = cur_q[CW-1:0];
    assign bus.cur_row = cur_q[AW-1:CW];
`else
    assign wr_addr_c = {bus.wr_row, bus.wr_col};
`endif

    // Next state, sweep counter and RAM port selection.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = rd_addr_c;
        ram_wdata = '0;

        case (state_q)
            IDLE: begin
                if (bus.clr_start && !rst) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_wr_c) begin
                    sweep_d = sweep_q + AW'(1);
                    if (sweep_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.rd_req) begin
            ram_re = 1'b1;
        end else if (clr_wr_c) begin
            ram_we   = 1'b1;
            ram_addr = sweep_q;
        end else if (wr_fire_c) begin
            ram_we    = 1'b1;
            ram_addr  = wr_addr_c;
            ram_wdata = bus.wr_char;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sweep_q    <= '0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            busy_q     <= (state_d == CLEAR);
            rd_valid_q <= bus.rd_req;
        end
    end

    text_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (CHAR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = ram_rdata;
    assign bus.busy     = busy_q;
    assign bus.wr_ready = wr_ready_c;

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Bench for text_buffer_arbiter: reference buffer model plus read
// scoreboard, a table of write/read vectors, and hand sequences for read
// priority, clears, read stalls, reset mid-clear and (optionally) the cursor.
module tb_text_buffer_arbiter;
    import text_pkg::*;

    localparam int unsigned COLS   = 32;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned CHAR_W = 7;
    localparam int unsigned CW     = 5;
    localparam int unsigned RW     = 4;
    localparam int unsigned AW     = 9;
    localparam int unsigned DEPTH  = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_buffer_arbiter_if #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W)) bus ();

    text_buffer_arbiter #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model
    logic [CHAR_W-1:0] m_mem [DEPTH];
    bit                m_clear;
    logic [AW-1:0]     m_cnt;
    logic [AW-1:0]     m_cur;
    logic [CHAR_W-1:0] sb_q [$];
    bit                exp_valid;
    logic [CHAR_W-1:0] last_rd;

    typedef struct {
        bit                wr;
        logic [RW-1:0]     row;
        logic [CW-1:0]     col;
        logic [CHAR_W-1:0] ch;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [RW-1:0] row,
                                input logic [CW-1:0] col, input logic [CHAR_W-1:0] ch);
        vec_t v;
        v.wr = wr; v.row = row; v.col = col; v.ch = ch;
        return v;
    endfunction

    task automatic idle();
        bus.rd_req    = 1'b0;
        bus.rd_col    = '0;
        bus.rd_row    = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_col    = '0;
        bus.wr_row    = '0;
        bus.wr_char   = '0;
        bus.clr_start = 1'b0;
`ifdef TEXT_BUFFER_CURSOR_EN
        bus.wr_auto   = 1'b0;
`endif
    endtask

    // One clock: check outputs of the previous edge, predict this edge.
    task automatic step();
        bit            rdy;
        logic [AW-1:0] wa;
        @(negedge clk);
        check("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
        if (exp_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(1), 32'(0));
            end else begin
                last_rd = sb_q.pop_front();
            end
        end
        check("rd_data", 32'(bus.rd_data), 32'(last_rd));
        check("busy", 32'(bus.busy), 32'(m_clear));
`ifdef TEXT_BUFFER_CURSOR_EN
        check("cur", 32'({bus.cur_row, bus.cur_col}), 32'(m_cur));
`endif
        rdy = !rst && !m_clear && !bus.rd_req && !bus.clr_start;
        check("wr_ready", 32'(bus.wr_ready), 32'(rdy));
        exp_valid = 1'b0;
        if (bus.rd_req && !rst) begin
            sb_q.push_back(m_mem[{bus.rd_row, bus.rd_col}]);
            exp_valid = 1'b1;
        end
        wa = {bus.wr_row, bus.wr_col};
`ifdef TEXT_BUFFER_CURSOR_EN
        if (bus.wr_auto) wa = m_cur;
`endif
        @(posedge clk);
        if (rst) begin
            m_clear   = 1'b0;
            m_cnt     = '0;
            m_cur     = '0;
            last_rd   = '0;
            exp_valid = 1'b0;
            sb_q.delete();
        end else if (m_clear) begin
            if (!bus.rd_req) begin
                m_mem[m_cnt] = '0;
                if (m_cnt == AW'(DEPTH - 1)) begin
                    m_clear = 1'b0;
                    m_cur   = '0;
                end
                m_cnt = m_cnt + AW'(1);
            end
        end else begin
            if (bus.wr_valid && rdy) begin
                m_mem[wa] = bus.wr_char;
`ifdef TEXT_BUFFER_CURSOR_EN
                if (bus.wr_auto) m_cur = m_cur + AW'(1);
`endif
            end
            if (bus.clr_start) m_clear = 1'b1;
        end
        #1;
    endtask

    task automatic fill(input logic [CHAR_W-1:0] ch);
        idle();
        bus.wr_valid = 1'b1;
        bus.wr_char  = ch;
        for (int a = 0; a < DEPTH; a++) begin
            {bus.wr_row, bus.wr_col} = AW'(a);
            step();
        end
        idle();
    endtask

    task automatic read_all();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_req = 1'b1;
            {bus.rd_row, bus.rd_col} = AW'(a);
            step();
        end
        idle();
        step();
    endtask

    task automatic run_clear(input int unsigned exp_cycles, input string name);
        int unsigned n;
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        n = 0;
        while (bus.busy && n < 2000) begin
            step();
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    initial begin
        int unsigned n;
        int unsigned reads;

        idle();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_clear = 1'b0; m_cnt = '0; m_cur = '0;
        exp_valid = 1'b0; last_rd = '0;

        // Reset
        rst = 1'b1;
        step();
        step();
        check("reset_rd_valid", 32'(bus.rd_valid), 32'(0));
        check("reset_rd_data", 32'(bus.rd_data), 32'(0));
        check("reset_busy", 32'(bus.busy), 32'(0));
        check("reset_wr_ready", 32'(bus.wr_ready), 32'(0));
        rst = 1'b0;
        step();

        // Table of writes and back-to-back reads
        tbl[0] = mk(1'b1, 4'd3,  5'd5,  7'h41);
        tbl[1] = mk(1'b0, 4'd3,  5'd5,  7'h41);
        tbl[2] = mk(1'b1, 4'd0,  5'd0,  7'h01);
        tbl[3] = mk(1'b1, 4'd15, 5'd31, 7'h7E);
        tbl[4] = mk(1'b0, 4'd0,  5'd0,  7'h01);
        tbl[5] = mk(1'b0, 4'd15, 5'd31, 7'h7E);
        tbl[6] = mk(1'b1, 4'd3,  5'd5,  7'h42);
        tbl[7] = mk(1'b0, 4'd3,  5'd5,  7'h42);
        tbl[8] = mk(1'b1, 4'd8,  5'd16, 7'h2A);
        tbl[9] = mk(1'b0, 4'd8,  5'd16, 7'h2A);
        for (int i = 0; i < 10; i++) begin
            idle();
            if (tbl[i].wr) begin
                bus.wr_valid = 1'b1;
                bus.wr_row   = tbl[i].row;
                bus.wr_col   = tbl[i].col;
                bus.wr_char  = tbl[i].ch;
                #1 check("tbl_wr_ready", 32'(bus.wr_ready), 32'(1));
                step();
            end else begin
                bus.rd_req = 1'b1;
                bus.rd_row = tbl[i].row;
                bus.rd_col = tbl[i].col;
                step();
                check("tbl_rd_valid", 32'(bus.rd_valid), 32'(1));
                check("tbl_rd_data", 32'(bus.rd_data), 32'(tbl[i].ch));
            end
        end
        idle();
        step();

        // Read priority over a waiting writer
        bus.wr_valid = 1'b1; bus.wr_row = 4'd2; bus.wr_col = 5'd7; bus.wr_char = 7'h33;
        bus.rd_req   = 1'b1; bus.rd_row = 4'd3; bus.rd_col = 5'd5;
        for (int i = 0; i < 10; i++) begin
            #1 check("prio_wr_ready", 32'(bus.wr_ready), 32'(0));
            step();
        end
        bus.rd_req = 1'b0;
        #1 check("prio_release_ready", 32'(bus.wr_ready), 32'(1));
        step();
        idle();
        bus.rd_req = 1'b1; bus.rd_row = 4'd2; bus.rd_col = 5'd7;
        step();
        check("prio_rd_data", 32'(bus.rd_data), 32'(7'h33));
        idle();
        step();

        // Full clear
        fill(7'h7F);
        run_clear(512, "clear_busy_cycles");
        read_all();
        check("clear_last_cell", 32'(bus.rd_data), 32'(0));

        // Clear with 20 overlapping display reads
        fill(7'h7F);
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        n = 0;
        reads = 0;
        while (bus.busy && n < 2000) begin
            if ((n % 25) == 3 && reads < 20) begin
                bus.rd_req = 1'b1;
                {bus.rd_row, bus.rd_col} = AW'($urandom_range(0, DEPTH - 1));
                reads++;
            end else begin
                bus.rd_req = 1'b0;
            end
            step();
            n++;
        end
        idle();
        check("stall_busy_cycles", n, 532);
        step();

        // Reset at sweep count 100
        fill(7'h7F);
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", 32'(bus.busy), 32'(0));
        for (int a = 0; a <= 100; a++) begin
            bus.rd_req = 1'b1;
            {bus.rd_row, bus.rd_col} = AW'(a);
            step();
            check("rst_mid_cell", 32'(bus.rd_data), (a < 100) ? 32'(0) : 32'(7'h7F));
        end
        idle();
        step();

        // Read + clr_start + writer together, writer held through the clear
        bus.rd_req    = 1'b1; bus.rd_row = 4'd2; bus.rd_col = 5'd7;
        bus.clr_start = 1'b1;
        bus.wr_valid  = 1'b1; bus.wr_row = 4'd4; bus.wr_col = 5'd9; bus.wr_char = 7'h55;
        #1 check("sim_wr_ready", 32'(bus.wr_ready), 32'(0));
        step();
        check("sim_rd_valid", 32'(bus.rd_valid), 32'(1));
        check("sim_busy", 32'(bus.busy), 32'(1));
        bus.rd_req    = 1'b0;
        bus.clr_start = 1'b0;
        n = 0;
        while (bus.busy && n < 2000) begin
            step();
            n++;
        end
        check("sim_busy_cycles", n, 512);
        #1 check("post_clear_ready", 32'(bus.wr_ready), 32'(1));
        step();
        idle();
        bus.rd_req = 1'b1; bus.rd_row = 4'd4; bus.rd_col = 5'd9;
        step();
        check("post_clear_write", 32'(bus.rd_data), 32'(7'h55));
        bus.rd_col = 5'd10;
        step();
        check("post_clear_zero", 32'(bus.rd_data), 32'(0));
        idle();
        step();

`ifdef TEXT_BUFFER_CURSOR_EN
        // Cursor: 512 auto writes wrap back to (0,0)
        bus.wr_valid = 1'b1;
        bus.wr_auto  = 1'b1;
        bus.wr_row   = 4'd9;
        bus.wr_col   = 5'd3;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_char = CHAR_W'(i);
            step();
            if (i == 30) check("cur_before_wrap", 32'({bus.cur_row, bus.cur_col}), 32'({4'd0, 5'd31}));
            if (i == 31) check("cur_after_wrap", 32'({bus.cur_row, bus.cur_col}), 32'({4'd1, 5'd0}));
        end
        check("cur_full_wrap", 32'({bus.cur_row, bus.cur_col}), 32'(0));
        idle();
        bus.rd_req = 1'b1; bus.rd_row = 4'd1; bus.rd_col = 5'd8;
        step();
        check("cur_cell_40", 32'(bus.rd_data), 32'(7'h28));
        idle();
        step();
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
